pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter N_BITS_REG, default 5, SHALL set the width of register-index inputs.
REQ-002 Parameter DRAIN_CYCLES, default 4, SHALL set the number of cycles spent draining after a halt.
REQ-003 Parameter N_BITS_CNT, default 32, SHALL set the width of o_cycle_count.
REQ-004 i_clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 i_mem_read_idex  input  1  SHALL flag a load in ID/EX.
REQ-007 i_rt_idex  input  N_BITS_REG  SHALL be the load destination register in ID/EX.
REQ-008 i_rs_ifid, i_rt_ifid  input  N_BITS_REG each  SHALL be the source registers of the instruction in IF/ID.
REQ-009 i_branch_taken  input  1  SHALL flag a taken branch/jump resolved in ID.
REQ-010 i_halt_id  input  1  SHALL flag a HALT instruction decoded in ID.
REQ-011 i_debug_mode, i_step  input  1 each  SHALL select single-step mode and request one step (level, edge-detected internally).
REQ-012 o_pc_write, o_ifid_write  output  1 each  SHALL enable the PC and IF/ID register loads.
REQ-013 o_idex_bubble, o_ifid_flush  output  1 each  SHALL zero ID/EX control and clear IF/ID respectively.
REQ-014 o_pipe_enable  output  1  SHALL globally enable all pipeline registers.
REQ-015 o_halted  output  1; o_state  output  3; o_cycle_count  output  N_BITS_CNT.

Function
REQ-016 States SHALL be RUN=0, WAIT_STEP=1, STEP=2, DRAIN=3, HALTED=4; o_state SHALL show the registered state.
REQ-017 load_use SHALL be i_mem_read_idex && i_rt_idex!=0 && (i_rt_idex==i_rs_ifid || i_rt_idex==i_rt_ifid), combinational.
REQ-018 In RUN/STEP with load_use: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_ifid_flush=0, same cycle.
REQ-019 In RUN/STEP with i_branch_taken and not load_use: o_ifid_flush=1, o_pc_write=1; load_use SHALL win when both occur.
REQ-020 In RUN/STEP with none of the above: o_pc_write=1, o_ifid_write=1, o_idex_bubble=0, o_ifid_flush=0.
REQ-021 i_halt_id in RUN/STEP without load_use SHALL move to DRAIN next cycle, loading the drain counter with DRAIN_CYCLES-1; a halt coinciding with load_use SHALL be ignored that cycle.
REQ-022 DRAIN: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_pipe_enable=1; counter decrements each cycle; at 0 go to HALTED; DRAIN ignores debug mode.
REQ-023 HALTED: o_pipe_enable=0, o_pc_write=0, o_ifid_write=0, o_halted=1; exit only through reset.
REQ-024 RUN with i_debug_mode=1 and no halt SHALL go to WAIT_STEP; the current cycle still executes normally.
REQ-025 WAIT_STEP: o_pipe_enable=0, o_pc_write=0, o_ifid_write=0, o_idex_bubble=0, o_ifid_flush=0; i_debug_mode=0 returns to RUN.
REQ-026 A rising edge of i_step (i_step=1, registered previous value 0) in WAIT_STEP SHALL go to STEP; a held i_step SHALL yield exactly one step.
REQ-027 STEP SHALL last exactly one cycle with o_pipe_enable=1 and RUN hazard rules; next state DRAIN on accepted halt, else WAIT_STEP if i_debug_mode, else RUN.
REQ-028 o_pipe_enable SHALL be 1 in RUN, STEP and DRAIN.
REQ-029 o_cycle_count SHALL increment by 1 on each cycle with o_pipe_enable=1, wrap modulo 2^N_BITS_CNT, and hold otherwise.

Reset
REQ-030 Reset SHALL asynchronously set state RUN, drain counter 0, o_cycle_count 0, registered i_step 0.
REQ-031 While i_reset=1, outputs SHALL be o_pc_write=0, o_ifid_write=0, o_idex_bubble=0, o_ifid_flush=0, o_pipe_enable=0, o_halted=0.
REQ-032 Reset asserted mid-DRAIN, HALTED or WAIT_STEP SHALL abort it; the first cycle after deassertion SHALL be RUN.

Configuration
REQ-033 Macro DEBUG_STEP_EN defined: REQ-024..REQ-027 SHALL apply.
REQ-034 Macro DEBUG_STEP_EN undefined: i_debug_mode and i_step SHALL be ignored, WAIT_STEP/STEP SHALL be unreachable, and RUN SHALL never enter them.

Verification
REQ-035 Load-use: i_mem_read_idex=1, i_rt_idex=5, i_rs_ifid=5 -> same cycle pc_write=0, ifid_write=0, idex_bubble=1; i_rt_idex=0 -> no stall.
REQ-036 Branch and load-use together (rt_idex=3=rt_ifid, branch_taken=1) -> stall only, ifid_flush=0; branch alone -> ifid_flush=1.
REQ-037 i_halt_id=1 for one cycle in RUN -> 4 DRAIN cycles with idex_bubble=1, then o_halted=1 and o_cycle_count frozen.
REQ-038 DEBUG_STEP_EN defined, debug_mode=1, i_step held high 5 cycles -> exactly one STEP cycle and o_cycle_count +1.
REQ-039 Reset pulsed during DRAIN with counter=2 -> outputs per REQ-031 immediately; RUN and count 0 after release.
REQ-040 Wrap: N_BITS_CNT=4, 16 RUN cycles -> o_cycle_count returns to 0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Pipeline hazard/halt sequencer: load-use stall, branch flush, halt drain and cycle counter.
// Optional single-step debug support is compiled in with `define DEBUG_STEP_EN.
module pipeline_sequencer #(
  parameter int unsigned N_BITS_REG   = 5,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned N_BITS_CNT   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_mem_read_idex,
  input  logic [N_BITS_REG-1:0] i_rt_idex,
  input  logic [N_BITS_REG-1:0] i_rs_ifid,
  input  logic [N_BITS_REG-1:0] i_rt_ifid,
  input  logic                  i_branch_taken,
  input  logic                  i_halt_id,
  input  logic                  i_debug_mode,
  input  logic                  i_step,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_idex_bubble,
  output logic                  o_ifid_flush,
  output logic                  o_pipe_enable,
  output logic                  o_halted,
  output logic [2:0]            o_state,
  output logic [N_BITS_CNT-1:0] o_cycle_count
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    StRun      = 3'd0,
    StWaitStep = 3'd1,
    StStep     = 3'd2,
    StDrain    = 3'd3,
    StHalted   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [DrainW-1:0]       drain_q, drain_d;
  logic [N_BITS_CNT-1:0]   count_q;

  logic load_use;
  logic halt_accept;
  logic pc_write, ifid_write, idex_bubble, ifid_flush, pipe_enable, halted;

`ifdef DEBUG_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise = i_step && !step_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= i_step;
    end
  end
`else
  // Debug inputs have no effect in this build.
  logic unused_dbg;
  assign unused_dbg = i_debug_mode ^ i_step;
`endif

  assign load_use = i_mem_read_idex && (i_rt_idex != '0) &&
                    ((i_rt_idex == i_rs_ifid) || (i_rt_idex == i_rt_ifid));
  assign halt_accept = i_halt_id && !load_use;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_enable = 1'b0;
    halted      = 1'b0;

    case (state_q)
      StRun, StStep: begin
        pipe_enable = 1'b1;
        if (load_use) begin
          idex_bubble = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = i_branch_taken;
        end

        if (halt_accept) begin
          state_d = StDrain;
          drain_d = DrainLoad;
        end else begin
          state_d = StRun;
`ifdef DEBUG_STEP_EN
          if (i_debug_mode) begin
            state_d = StWaitStep;
          end
`endif
        end
      end

`ifdef DEBUG_STEP_EN
      StWaitStep: begin
        if (!i_debug_mode) begin
          state_d = StRun;
        end else if (step_rise) begin
          state_d = StStep;
        end
      end
`endif

      StDrain: begin
        pipe_enable = 1'b1;
        idex_bubble = 1'b1;
        if (drain_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      StHalted: begin
        halted = 1'b1;
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StRun;
      drain_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (pipe_enable) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Control outputs are forced inactive for as long as reset is held.
  assign o_pc_write    = pc_write    && !i_reset;
  assign o_ifid_write  = ifid_write  && !i_reset;
  assign o_idex_bubble = idex_bubble && !i_reset;
  assign o_ifid_flush  = ifid_flush  && !i_reset;
  assign o_pipe_enable = pipe_enable && !i_reset;
  assign o_halted      = halted      && !i_reset;
  assign o_state       = state_q;
  assign o_cycle_count = count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized self-checking bench for pipeline_sequencer against a cycle-level behavioural model.
module tb_pipeline_sequencer;

  localparam int unsigned NReg   = 5;
  localparam int unsigned NDrain = 4;
  localparam int unsigned NCnt   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mem_read_idex = 1'b0;
  logic [NReg-1:0] rt_idex = '0, rs_ifid = '0, rt_ifid = '0;
  logic            branch_taken = 1'b0, halt_id = 1'b0, debug_mode = 1'b0, step = 1'b0;
  logic            pc_write, ifid_write, idex_bubble, ifid_flush, pipe_enable, halted;
  logic [2:0]      state;
  logic [NCnt-1:0] cycle_count;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 run, 1 wait-step, 2 step, 3 drain, 4 halted.
  int          m_mode = 0;
  int          m_left = 0;
  int unsigned m_cnt = 0;
  bit          m_prev_step = 1'b0;

  pipeline_sequencer #(
    .N_BITS_REG  (NReg),
    .DRAIN_CYCLES(NDrain),
    .N_BITS_CNT  (NCnt)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_mem_read_idex(mem_read_idex),
    .i_rt_idex      (rt_idex),
    .i_rs_ifid      (rs_ifid),
    .i_rt_ifid      (rt_ifid),
    .i_branch_taken (branch_taken),
    .i_halt_id      (halt_id),
    .i_debug_mode   (debug_mode),
    .i_step         (step),
    .o_pc_write     (pc_write),
    .o_ifid_write   (ifid_write),
    .o_idex_bubble  (idex_bubble),
    .o_ifid_flush   (ifid_flush),
    .o_pipe_enable  (pipe_enable),
    .o_halted       (halted),
    .o_state        (state),
    .o_cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit r, input bit mr, input int rti, input int rsf, input int rtf,
                       input bit br, input bit ht, input bit dbg, input bit stp);
    bit lu, ha, dbg_en;
    logic [5:0] exp_v, mask, obs_v;
    @(negedge clk);
    rst = r; mem_read_idex = mr; rt_idex = NReg'(rti); rs_ifid = NReg'(rsf);
    rt_ifid = NReg'(rtf); branch_taken = br; halt_id = ht; debug_mode = dbg; step = stp;
    #1;
`ifdef DEBUG_STEP_EN
    dbg_en = 1'b1;
`else
    dbg_en = 1'b0;
`endif
    if (r) begin
      m_mode = 0; m_cnt = 0; m_left = 0; m_prev_step = 1'b0;
    end
    lu = mr && (rti != 0) && ((rti == rsf) || (rti == rtf));
    ha = ht && !lu;
    // {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_enable, halted}
    mask = 6'b111111;
    if (r) exp_v = 6'b000000;
    else if (m_mode == 0 || m_mode == 2) begin
      if (lu) exp_v = 6'b001010;
      else if (br) begin exp_v = 6'b110110; mask = 6'b101111; end
      else exp_v = 6'b110010;
    end else if (m_mode == 1) exp_v = 6'b000000;
    else if (m_mode == 3) begin exp_v = 6'b001010; mask = 6'b111011; end
    else begin exp_v = 6'b000001; mask = 6'b110011; end
    obs_v = {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_enable, halted};
    check_eq("ctrl_outputs", 32'(obs_v & mask), 32'(exp_v & mask));
    check_eq("state", 32'(state), 32'(m_mode));
    check_eq("cycle_count", 32'(cycle_count), 32'(m_cnt % (1 << NCnt)));
    if (!r) begin
      case (m_mode)
        0: begin
          m_cnt++;
          if (ha) begin m_mode = 3; m_left = NDrain; end
          else if (dbg_en && dbg) m_mode = 1;
        end
        1: begin
          if (!dbg) m_mode = 0;
          else if (stp && !m_prev_step) m_mode = 2;
        end
        2: begin
          m_cnt++;
          if (ha) begin m_mode = 3; m_left = NDrain; end
          else m_mode = dbg ? 1 : 0;
        end
        3: begin
          m_cnt++;
          m_left--;
          if (m_left == 0) m_mode = 4;
        end
        default: ;
      endcase
      m_prev_step = stp;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use stall, then destination register zero.
    cycle(0, 1, 5, 5, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Branch together with load-use, then branch alone.
    cycle(0, 1, 3, 0, 3, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Halt coinciding with load-use is ignored.
    cycle(0, 1, 2, 2, 0, 0, 1, 0, 0);
    // Enough plain cycles to wrap the 4-bit counter.
    idle(16);
    // Halt: drain then halted with frozen count.
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(8);
    // Reset during drain.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
`ifdef DEBUG_STEP_EN
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
`endif
    // Random episodes, each opening with reset.
    for (int ep = 0; ep < 30; ep++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 80; i++) begin
        cycle($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
